// File: rtl/steer_if.sv
// Request and step handshake bundle between key/assist logic, the move scheduler and the phase sequencer.
// slave = scheduler side, master = the requesters / step consumer side.
interface steer_if #(
  parameter int POS_W = 8
);
  // Handshakes: a request or step transfers on a rising clk edge where valid and ready are both 1.
  // Request ready is a one-cycle acceptance pulse. step_valid/step_dir hold until step_ready.
  logic             req_a_valid;
  logic [POS_W-1:0] req_a_target;
  logic             req_a_ready;
  logic             req_b_valid;
  logic [POS_W-1:0] req_b_target;
  logic             req_b_ready;
  logic             step_valid;
  logic             step_dir;
  logic             step_ready;

  modport slave (
    input  req_a_valid, req_a_target, req_b_valid, req_b_target, step_ready,
    output req_a_ready, req_b_ready, step_valid, step_dir
  );

  modport master (
    output req_a_valid, req_a_target, req_b_valid, req_b_target, step_ready,
    input  req_a_ready, req_b_ready, step_valid, step_dir
  );
endinterface

// File: rtl/steer_move_scheduler.sv
// Two-source steering target arbiter with paced single-step output and absolute position tracking.
// Optional SOFT_RAMP_EN: first RAMP_STEPS steps after an accept/preempt use a doubled interval.
module steer_move_scheduler #(
  parameter int POS_W      = 8,
  parameter int LIMIT_POS  = 75,
  parameter int DIV_FAST   = 900_000,
  parameter int DIV_SLOW   = 1_600_000,
  parameter int RAMP_STEPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             engine_on,
  input  logic             abort,
  steer_if.slave           bus,
  output logic [POS_W-1:0] cur_pos,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DONE} state_t;

  localparam int DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int CNT_W   = $clog2(2 * DIV_MAX);
  localparam logic signed [POS_W-1:0] LIM_P = POS_W'(LIMIT_POS);
  localparam logic signed [POS_W-1:0] LIM_N = POS_W'(-LIMIT_POS);
  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_A    = 2'b01;
  localparam logic [1:0] G_B    = 2'b10;

  state_t                   r_state, w_state_nxt;
  logic signed [POS_W-1:0]  r_pos, w_pos_nxt;
  logic signed [POS_W-1:0]  r_target, w_target_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic [1:0]               r_grant, w_grant_nxt;
  logic                     r_dir, w_dir_nxt;
  logic                     r_abort_pend, w_abort_nxt;

  logic                     w_acc_a, w_acc_b;
  logic                     w_new_owner;
  logic signed [POS_W-1:0]  w_new_tgt, w_tgt_eff;
  logic [CNT_W-1:0]         w_base_ival, w_acc_ival, w_rel_ival;

  function automatic logic signed [POS_W-1:0] clamp_tgt(input logic signed [POS_W-1:0] t);
    if (t > LIM_P)      return LIM_P;
    else if (t < LIM_N) return LIM_N;
    else                return t;
  endfunction

  assign w_base_ival = engine_on ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_SLOW - 1);

  // Arbitration: A always wins; B is only taken from IDLE or as a re-target of its own grant.
  always_comb begin
    w_acc_a = 1'b0;
    w_acc_b = 1'b0;
    if (!abort) begin
      if (r_state == S_IDLE) begin
        w_acc_a = bus.req_a_valid;
        w_acc_b = !bus.req_a_valid && bus.req_b_valid;
      end else if (r_state == S_WAIT) begin
        w_acc_a = bus.req_a_valid;
        w_acc_b = !bus.req_a_valid && bus.req_b_valid && (r_grant == G_B);
      end
    end
  end

  assign w_new_tgt   = clamp_tgt(w_acc_a ? $signed(bus.req_a_target) : $signed(bus.req_b_target));
  assign w_tgt_eff   = (w_acc_a || w_acc_b) ? w_new_tgt : r_target;
  assign w_new_owner = ((r_state == S_IDLE) && (w_acc_a || w_acc_b)) ||
                       ((r_state == S_WAIT) && w_acc_a && (r_grant == G_B));

`ifdef SOFT_RAMP_EN
  localparam int RW = $clog2(RAMP_STEPS + 1);
  logic [RW-1:0] r_ramp, w_ramp_nxt;

  assign w_acc_ival = CNT_W'({1'b0, w_base_ival} << 1) + CNT_W'(1);
  assign w_rel_ival = (r_ramp != '0) ? w_acc_ival : w_base_ival;

  // From IDLE the first doubled interval is loaded at accept; a preempt keeps the running count.
  always_comb begin
    w_ramp_nxt = r_ramp;
    if (w_new_owner)
      w_ramp_nxt = (r_state == S_IDLE) ? RW'(RAMP_STEPS - 1) : RW'(RAMP_STEPS);
    else if ((r_state == S_ISSUE) && bus.step_ready && (r_ramp != '0))
      w_ramp_nxt = r_ramp - RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ramp <= '0;
    else        r_ramp <= w_ramp_nxt;
  end
`else
  assign w_acc_ival = w_base_ival;
  assign w_rel_ival = w_base_ival;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_nxt    = r_pos;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_grant_nxt  = r_grant;
    w_dir_nxt    = r_dir;
    w_abort_nxt  = r_abort_pend;
    case (r_state)
      S_IDLE: begin
        w_abort_nxt = 1'b0;
        if (w_acc_a || w_acc_b) begin
          w_state_nxt  = S_WAIT;
          w_target_nxt = w_new_tgt;
          w_grant_nxt  = w_acc_a ? G_A : G_B;
          w_cnt_nxt    = w_acc_ival;
        end
      end
      S_WAIT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = G_NONE;
        end else begin
          w_target_nxt = w_tgt_eff;
          if (w_acc_a) w_grant_nxt = G_A;
          if (r_cnt == '0) begin
            if (w_tgt_eff == r_pos) begin
              w_state_nxt = S_DONE;
              w_grant_nxt = G_NONE;
            end else begin
              w_state_nxt = S_ISSUE;
              w_dir_nxt   = (w_tgt_eff > r_pos);
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (abort) w_abort_nxt = 1'b1;
        if (bus.step_ready) begin
          w_pos_nxt = r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
          w_cnt_nxt = w_rel_ival;
          if (abort || r_abort_pend) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = G_NONE;
            w_abort_nxt = 1'b0;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = G_NONE;
        w_abort_nxt = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pos        <= '0;
      r_target     <= '0;
      r_cnt        <= '0;
      r_grant      <= G_NONE;
      r_dir        <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pos        <= w_pos_nxt;
      r_target     <= w_target_nxt;
      r_cnt        <= w_cnt_nxt;
      r_grant      <= w_grant_nxt;
      r_dir        <= w_dir_nxt;
      r_abort_pend <= w_abort_nxt;
    end
  end

  assign bus.req_a_ready = w_acc_a;
  assign bus.req_b_ready = w_acc_b;
  assign bus.step_valid  = (r_state == S_ISSUE);
  assign bus.step_dir    = r_dir;
  assign cur_pos         = r_pos;
  assign grant           = r_grant;
  assign busy            = (r_state != S_IDLE);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_steer_move_scheduler.sv
// Directed bench for steer_move_scheduler with DIV_FAST=4, DIV_SLOW=8, LIMIT_POS=5.
module tb_steer_move_scheduler;

  logic       clk;
  logic       rst_n;
  logic       engine_on;
  logic       abort;
  logic [7:0] cur_pos;
  logic [1:0] grant;
  logic       busy;
  logic [1:0] dbg_state;

  steer_if #(.POS_W(8)) bus ();

  steer_move_scheduler #(
    .POS_W(8), .LIMIT_POS(5), .DIV_FAST(4), .DIV_SLOW(8), .RAMP_STEPS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .engine_on(engine_on), .abort(abort),
    .bus(bus.slave), .cur_pos(cur_pos), .grant(grant), .busy(busy),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  // scoreboard
  logic [0:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int last_hs = -1;
  int exp_gap = 5;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pos_i();
    return int'($signed(cur_pos));
  endfunction

  // step monitor: every handshake must be expected, in order, paced and in range
  always @(negedge clk) begin
    if (rst_n && bus.step_valid && bus.step_ready) begin
      check("step_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("step_dir", int'(bus.step_dir), int'(exp_q.pop_front()));
      if (last_hs >= 0) check("step_gap", cyc - last_hs, exp_gap);
      last_hs = cyc;
      check("pos_in_range", int'(pos_i() >= -5 && pos_i() <= 5), 1);
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    last_hs = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input bit src_b, input int tgt, input bit exp_rdy);
    if (src_b) begin
      bus.req_b_valid = 1'b1; bus.req_b_target = 8'(tgt);
    end else begin
      bus.req_a_valid = 1'b1; bus.req_a_target = 8'(tgt);
    end
    #1;
    if (src_b) check("b_ready", int'(bus.req_b_ready), int'(exp_rdy));
    else       check("a_ready", int'(bus.req_a_ready), int'(exp_rdy));
    @(posedge clk); #1;
    bus.req_a_valid = 1'b0;
    bus.req_b_valid = 1'b0;
  endtask

  task automatic push_steps(input int n, input bit dir);
    for (int i = 0; i < n; i++) exp_q.push_back(dir);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    check(tag, int'(got), 1);
  endtask

  task automatic wait_pos(input string tag, input int p, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (pos_i() == p) got = 1'b1;
    end
    check(tag, int'(got), 1);
  endtask

  task automatic wait_step_valid(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (bus.step_valid) got = 1'b1;
    end
    check(tag, int'(got), 1);
  endtask

  initial begin
    rst_n = 1'b0; engine_on = 1'b1; abort = 1'b0;
    bus.req_a_valid = 1'b0; bus.req_a_target = '0;
    bus.req_b_valid = 1'b0; bus.req_b_target = '0;
    bus.step_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pos", pos_i(), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step_valid", int'(bus.step_valid), 0);
    rst_n = 1'b1;

    // A +3, engine on: three right steps, 5 clk apart
    @(posedge clk); #1;
    exp_gap = 5; last_hs = -1; push_steps(3, 1'b1);
    send(1'b0, 3, 1'b1);
    check("a3_grant", int'(grant), 1);
    check("a3_busy", int'(busy), 1);
    wait_idle("a3_idle", 200);
    check("a3_pos", pos_i(), 3);
    check("a3_grant_end", int'(grant), 0);
    check("a3_q_empty", exp_q.size(), 0);

    // B -9, engine off: clamped to -5, five left steps 9 clk apart
    do_reset();
    engine_on = 1'b0; exp_gap = 9; last_hs = -1; push_steps(5, 1'b0);
    send(1'b1, -9, 1'b1);
    check("b9_grant", int'(grant), 2);
    wait_idle("b9_idle", 300);
    check("b9_pos", pos_i(), -5);
    check("b9_q_empty", exp_q.size(), 0);

    // B +4 preempted by A 0 after two steps
    do_reset();
    engine_on = 1'b1; exp_gap = 5; last_hs = -1;
    push_steps(2, 1'b1); push_steps(2, 1'b0);
    send(1'b1, 4, 1'b1);
    wait_pos("pre_reach2", 2, 100);
    send(1'b0, 0, 1'b1);
    check("pre_grant_a", int'(grant), 1);
    send(1'b1, 5, 1'b0);
    check("pre_grant_keep", int'(grant), 1);
    wait_idle("pre_idle", 200);
    check("pre_pos", pos_i(), 0);
    check("pre_q_empty", exp_q.size(), 0);

    // re-target by same owner: A +3, after one step A -1
    exp_gap = 5; last_hs = -1;
    push_steps(1, 1'b1); push_steps(2, 1'b0);
    send(1'b0, 3, 1'b1);
    wait_pos("rt_reach1", 1, 100);
    send(1'b0, -1, 1'b1);
    wait_idle("rt_idle", 200);
    check("rt_pos", pos_i(), -1);
    check("rt_q_empty", exp_q.size(), 0);

    // step_ready held low 10 clk in ISSUE
    do_reset();
    bus.step_ready = 1'b0; last_hs = -1; push_steps(1, 1'b1);
    send(1'b0, 1, 1'b1);
    wait_step_valid("stall_issue", 50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", int'(bus.step_valid), 1);
      check("stall_dir", int'(bus.step_dir), 1);
      check("stall_pos", pos_i(), 0);
    end
    @(posedge clk); #1;
    bus.step_ready = 1'b1;
    wait_idle("stall_idle", 100);
    check("stall_pos_end", pos_i(), 1);

    // asynchronous reset while a step is pending
    bus.step_ready = 1'b0; push_steps(2, 1'b1);
    send(1'b0, 3, 1'b1);
    wait_step_valid("mid_issue", 50);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus.step_valid), 0);
    check("mid_rst_pos", pos_i(), 0);
    check("mid_rst_grant", int'(grant), 0);
    check("mid_rst_busy", int'(busy), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.step_ready = 1'b1;

    // abort beats a same-cycle A request in WAIT
    engine_on = 1'b0; last_hs = -1;
    send(1'b0, 2, 1'b1);
    abort = 1'b1;
    send(1'b0, -3, 1'b0);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_grant", int'(grant), 0);
    repeat (30) @(negedge clk);
    check("abort_pos", pos_i(), 0);
    check("abort_state", int'(dbg_state), 0);

    // A and B together from IDLE; A target equals position so no step
    engine_on = 1'b1;
    bus.req_b_valid = 1'b1; bus.req_b_target = 8'(5);
    bus.req_a_valid = 1'b1; bus.req_a_target = 8'(0);
    #1;
    check("both_a_ready", int'(bus.req_a_ready), 1);
    check("both_b_ready", int'(bus.req_b_ready), 0);
    @(posedge clk); #1;
    bus.req_a_valid = 1'b0; bus.req_b_valid = 1'b0;
    check("both_grant", int'(grant), 1);
    wait_idle("same_idle", 50);
    check("same_pos", pos_i(), 0);
    check("same_q_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
